data_cache: RTL

- Direct-mapped, write-back, write-allocate data cache between the CPU load/store path and the 32-bit-block data memory.
- Consumes CPU signals READ, WRITE, RESULT (address) and REGOUT1 (store data).
- Returns READDATA and BUSYWAIT to the CPU.
- Stalls the CPU through BUSYWAIT on misses while it runs writeback and fetch handshakes with memory.

---
 rtl/data_cache_pkg.sv | 14 +
 rtl/data_cache_block_array.sv | 52 +++++
 rtl/data_cache.sv | 96 +++++++++
 3 files changed

// File: rtl/data_cache_pkg.sv
// Shared field widths and controller state encoding for the direct-mapped data cache.
package data_cache_pkg;
  localparam int TAG_BITS    = 3;
  localparam int INDEX_BITS  = 3;
  localparam int OFFSET_BITS = 2;
  localparam int BLOCK_BITS  = 32;
  localparam int NUM_BLOCKS  = 2 ** INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2
  } state_t;
endpackage

// File: rtl/data_cache_block_array.sv
// Valid/dirty/tag/data storage: one write port (byte store or block fill), combinational read.
module cache_block_array
  import data_cache_pkg::*;
(
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [INDEX_BITS-1:0]  i_index,
  input  logic                   i_byte_we,
  input  logic [OFFSET_BITS-1:0] i_offset,
  input  logic [7:0]             i_byte,
  input  logic                   i_fill_we,
  input  logic [TAG_BITS-1:0]    i_fill_tag,
  input  logic [BLOCK_BITS-1:0]  i_fill_data,
  output logic                   o_valid,
  output logic                   o_dirty,
  output logic [TAG_BITS-1:0]    o_tag,
  output logic [BLOCK_BITS-1:0]  o_data
);
  logic [NUM_BLOCKS-1:0] r_valid;
  logic [NUM_BLOCKS-1:0] r_dirty;
  logic [TAG_BITS-1:0]   r_tag  [NUM_BLOCKS];
  logic [BLOCK_BITS-1:0] r_data [NUM_BLOCKS];

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_fill_we) begin
      r_valid[i_index] <= 1'b1;
      r_dirty[i_index] <= 1'b0;
    end else if (i_byte_we) begin
      r_dirty[i_index] <= 1'b1;
    end
  end

  // Tag and data carry no reset; contents are meaningless until valid is set.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      if (i_fill_we) begin
        r_tag[i_index]  <= i_fill_tag;
        r_data[i_index] <= i_fill_data;
      end else if (i_byte_we) begin
        r_data[i_index][{i_offset, 3'b000} +: 8] <= i_byte;
      end
    end
  end

  assign o_valid = r_valid[i_index];
  assign o_dirty = r_dirty[i_index];
  assign o_tag   = r_tag[i_index];
  assign o_data  = r_data[i_index];
endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back/write-allocate cache; hits serve in the same cycle,
// misses stall the CPU on BUSYWAIT through optional writeback then fetch.
module data_cache
  import data_cache_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT
);
  state_t r_state;
  state_t w_next;
  logic   r_issued;

  logic [TAG_BITS-1:0]    w_tag;
  logic [INDEX_BITS-1:0]  w_index;
  logic [OFFSET_BITS-1:0] w_offset;
  logic                   w_valid, w_dirty, w_hit, w_req, w_done;
  logic                   w_byte_we, w_fill_we;
  logic [TAG_BITS-1:0]    w_blk_tag;
  logic [BLOCK_BITS-1:0]  w_blk_data;

  assign w_tag    = ADDRESS[7 -: TAG_BITS];
  assign w_index  = ADDRESS[OFFSET_BITS +: INDEX_BITS];
  assign w_offset = ADDRESS[OFFSET_BITS-1:0];

  assign w_req  = READ | WRITE;
  assign w_hit  = w_valid && (w_blk_tag == w_tag);
  // The first cycle of a handshake is ignored so a slow-to-rise MEM_BUSYWAIT is not taken as done.
  assign w_done = r_issued && !MEM_BUSYWAIT;

  assign w_byte_we = (r_state == IDLE) && WRITE && w_hit;
  assign w_fill_we = (r_state == FETCH) && w_done;

  assign BUSYWAIT      = w_req && !((r_state == IDLE) && w_hit);
  assign READDATA      = w_blk_data[{w_offset, 3'b000} +: 8];
  assign MEM_WRITEDATA = w_blk_data;

  cache_block_array u_array (
    .CLK         (CLK),
    .RESET       (RESET),
    .i_index     (w_index),
    .i_byte_we   (w_byte_we),
    .i_offset    (w_offset),
    .i_byte      (WRITEDATA),
    .i_fill_we   (w_fill_we),
    .i_fill_tag  (w_tag),
    .i_fill_data (MEM_READDATA),
    .o_valid     (w_valid),
    .o_dirty     (w_dirty),
    .o_tag       (w_blk_tag),
    .o_data      (w_blk_data)
  );

  always_comb begin
    w_next      = r_state;
    MEM_READ    = 1'b0;
    MEM_WRITE   = 1'b0;
    MEM_ADDRESS = {w_tag, w_index};
    case (r_state)
      IDLE: begin
        if (w_req && !w_hit) w_next = w_dirty ? WRITEBACK : FETCH;
      end
      WRITEBACK: begin
        MEM_WRITE   = 1'b1;
        MEM_ADDRESS = {w_blk_tag, w_index};
        if (w_done) w_next = FETCH;
      end
      FETCH: begin
        MEM_READ = 1'b1;
        if (w_done) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state  <= IDLE;
      r_issued <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_issued <= (w_next == r_state) && (r_state != IDLE);
    end
  end
endmodule
